// File: rtl/yuv_pkg.sv
// Shared types, offsets and BT.601 coefficients for the Y'UV444 -> XRGB8888 stage.
// Define YUV2RGB_FULL_RANGE_EN to select full-range (JPEG) coefficients instead of limited range.
package yuv_pkg;

    localparam int CHROMA_OFFSET = 128;
    localparam int LIM_Y_OFFSET  = 16;
    localparam int FULL_Y_OFFSET = 0;

    localparam int LIM_K_Y  = 298;
    localparam int LIM_K_RV = 409;
    localparam int LIM_K_GU = 100;
    localparam int LIM_K_GV = 208;
    localparam int LIM_K_BU = 516;

    localparam int FULL_K_Y  = 256;
    localparam int FULL_K_RV = 359;
    localparam int FULL_K_GU = 88;
    localparam int FULL_K_GV = 183;
    localparam int FULL_K_BU = 454;

`ifdef YUV2RGB_FULL_RANGE_EN
    localparam int Y_OFFSET = FULL_Y_OFFSET;
    localparam int K_Y  = FULL_K_Y;
    localparam int K_RV = FULL_K_RV;
    localparam int K_GU = FULL_K_GU;
    localparam int K_GV = FULL_K_GV;
    localparam int K_BU = FULL_K_BU;
`else
    localparam int Y_OFFSET = LIM_Y_OFFSET;
    localparam int K_Y  = LIM_K_Y;
    localparam int K_RV = LIM_K_RV;
    localparam int K_GU = LIM_K_GU;
    localparam int K_GV = LIM_K_GV;
    localparam int K_BU = LIM_K_BU;
`endif

    typedef logic signed [19:0] acc_t;

    localparam acc_t ROUND = 20'sd128;

    typedef struct packed {
        logic [7:0] pad;
        logic [7:0] y;
        logic [7:0] u;
        logic [7:0] v;
    } yuv444_pix_t;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } xrgb_pix_t;

    // Arithmetic >>> 8 is bits [19:8]; then saturate that signed value to [0,255].
    function automatic logic [7:0] clamp_u8(input acc_t sum);
        logic signed [11:0] q;
        logic [7:0]         res;
        q = sum[19:8];
        if (q[11])
            res = 8'h00;
        else if (|q[10:8])
            res = 8'hFF;
        else
            res = q[7:0];
        return res;
    endfunction

endpackage

// File: rtl/yuv2rgb_lane.sv
// One-pixel 3-stage colour matrix: S1 products, S2 rounded sums, S3 shift/clamp.
// Coefficients come from yuv_pkg (YUV2RGB_FULL_RANGE_EN selects full range).
module yuv2rgb_lane
    import yuv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en1,
    input  logic        en2,
    input  logic        en3,
    input  logic [31:0] pix_in,
    output logic [31:0] pix_out
);

    yuv444_pix_t       pix;
    logic signed [8:0] c;
    logic signed [8:0] d;
    logic signed [8:0] e;
    logic              unused_pad;

    acc_t      p_y, p_rv, p_gu, p_gv, p_bu;
    acc_t      s_r, s_g, s_b;
    xrgb_pix_t out_q;

    assign pix        = yuv444_pix_t'(pix_in);
    assign unused_pad = ^pix.pad;

    assign c = 9'($signed({1'b0, pix.y}) - Y_OFFSET);
    assign d = 9'($signed({1'b0, pix.u}) - CHROMA_OFFSET);
    assign e = 9'($signed({1'b0, pix.v}) - CHROMA_OFFSET);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_y   <= '0;
            p_rv  <= '0;
            p_gu  <= '0;
            p_gv  <= '0;
            p_bu  <= '0;
            s_r   <= '0;
            s_g   <= '0;
            s_b   <= '0;
            out_q <= '0;
        end else begin
            if (en1) begin
                p_y  <= acc_t'(c * K_Y);
                p_rv <= acc_t'(e * K_RV);
                p_gu <= acc_t'(d * K_GU);
                p_gv <= acc_t'(e * K_GV);
                p_bu <= acc_t'(d * K_BU);
            end
            if (en2) begin
                s_r <= p_y + p_rv + ROUND;
                s_g <= p_y - p_gu - p_gv + ROUND;
                s_b <= p_y + p_bu + ROUND;
            end
            if (en3) begin
                out_q <= '{x: 8'h00, r: clamp_u8(s_r), g: clamp_u8(s_g), b: clamp_u8(s_b)};
            end
        end
    end

    assign pix_out = out_q;

endmodule

// File: rtl/yuv444_to_rgb.sv
// Packed Y'UV444 -> XRGB8888 stream stage: L lanes of yuv2rgb_lane plus valid/sideband pipeline.
// Define YUV2RGB_FULL_RANGE_EN for full-range conversion; timing and ports are unchanged.
module yuv444_to_rgb
    import yuv_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEST_WIDTH = 1
) (
    input  logic                    aclk,
    input  logic                    areset,

    input  logic                    src_t_valid,
    output logic                    src_t_ready,
    input  logic [DATA_WIDTH-1:0]   src_t_data,
    input  logic [DATA_WIDTH/8-1:0] src_t_keep,
    input  logic [DATA_WIDTH/8-1:0] src_t_strb,
    input  logic                    src_t_last,
    input  logic [DEST_WIDTH-1:0]   src_t_dest,

    output logic                    dst_t_valid,
    input  logic                    dst_t_ready,
    output logic [DATA_WIDTH-1:0]   dst_t_data,
    output logic [DATA_WIDTH/8-1:0] dst_t_keep,
    output logic [DATA_WIDTH/8-1:0] dst_t_strb,
    output logic                    dst_t_last,
    output logic [DEST_WIDTH-1:0]   dst_t_dest
);

    localparam int LANES = DATA_WIDTH / 32;

    logic                  v1, v2, v3;
    logic                  last1, last2, last3;
    logic [DEST_WIDTH-1:0] dest1, dest2, dest3;
    logic                  adv1, adv2, adv3;
    logic                  take, en1, en2, en3;

    // Each stage moves when its successor is empty or itself moving.
    assign adv3 = !v3 || dst_t_ready;
    assign adv2 = !v2 || adv3;
    assign adv1 = !v1 || adv2;

    assign src_t_ready = adv1 && !areset;
    assign take        = src_t_valid && src_t_ready;
    assign en1         = take;
    assign en2         = adv2 && v1;
    assign en3         = adv3 && v2;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            v3    <= 1'b0;
            last1 <= 1'b0;
            last2 <= 1'b0;
            last3 <= 1'b0;
            dest1 <= '0;
            dest2 <= '0;
            dest3 <= '0;
        end else begin
            if (adv1) v1 <= take;
            if (adv2) v2 <= v1;
            if (adv3) v3 <= v2;
            if (en1) begin
                last1 <= src_t_last;
                dest1 <= src_t_dest;
            end
            if (en2) begin
                last2 <= last1;
                dest2 <= dest1;
            end
            if (en3) begin
                last3 <= last2;
                dest3 <= dest2;
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        yuv2rgb_lane u_lane (
            .clk     (aclk),
            .rst     (areset),
            .en1     (en1),
            .en2     (en2),
            .en3     (en3),
            .pix_in  (src_t_data[32*k +: 32]),
            .pix_out (dst_t_data[32*k +: 32])
        );
    end

    assign dst_t_valid = v3;
    assign dst_t_last  = last3;
    assign dst_t_dest  = dest3;
    assign dst_t_keep  = '1;
    assign dst_t_strb  = '1;

    null_byte_chk: assert property (@(posedge aclk) disable iff (areset)
        (src_t_valid && src_t_ready) |-> (&src_t_keep && &src_t_strb))
        else $error("Null byte not supported");

endmodule
